// File: rtl/rca_pkg.sv
// Shared constants for the ripple-carry adder family (RCA_8bit and serial_add_ctrl).
// Contents:
//   ST_IDLE/ST_RUN/ST_DONE : state encodings of the serial adder sequencer
//   RCA_WIDTH              : default operand width
//   state_e                : typed state enum built on the encodings above
package rca_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int unsigned RCA_WIDTH = 8;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StRun  = ST_RUN,
    StDone = ST_DONE
  } state_e;

endpackage

// File: rtl/fa.sv
// One-bit full adder leaf cell shared by the ripple chain and the serial adder.
// Ports:
//   a, b : addend bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: accepts an add job over a valid/ready handshake, feeds one
// bit per cycle (LSB first) through a single full-adder cell, then presents sum and
// carry-out over a second valid/ready handshake.
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   in_valid/in_ready   : job handshake (ready only in IDLE)
//   in_a, in_b, in_ci   : operands and carry-in, captured on the accept edge
//   out_valid/out_ready : result handshake (valid only in DONE)
//   out_s, out_co       : sum and carry-out, flop-driven
//   busy                : high while a job is in RUN or DONE
module serial_add_ctrl
  import rca_pkg::*;
#(
  parameter  int unsigned WIDTH = RCA_WIDTH,
  localparam int unsigned CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_co,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic fa_s, fa_co;

  fa U0_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_ci;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands at s_q[0].
        s_d     = {fa_s, s_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_co;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  // All outputs decode from flops only; no input reaches an output combinationally.
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_s     = s_q;
  assign out_co    = carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_ci;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_s;
  logic         out_co;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_ci     (in_ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_co    (out_co),
    .busy      (busy)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one job from IDLE, scramble operands every RUN cycle, wait for out_valid.
  task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         output int lat, output int bc,
                         output logic [W-1:0] s, output logic co);
    @(negedge clk);
    in_a     = a;
    in_b     = b;
    in_ci    = ci;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    bc  = 0;
    while (!out_valid && lat < 20) begin
      if (busy) bc++;
      in_a  = W'($urandom);
      in_b  = W'($urandom);
      in_ci = 1'($urandom);
      @(posedge clk);
      #1;
      lat++;
    end
    if (busy) bc++;
    s  = out_s;
    co = out_co;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int           lat, bc, jobs, acc_edge, iters;
    logic [W-1:0] s;
    logic         co;
    logic [W:0]   exp_sum;
    bit           first;

    vecs[0] = '{a: 8'h00, b: 8'h00, ci: 1'b0, s: 8'h00, co: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, ci: 1'b0, s: 8'h00, co: 1'b1};
    vecs[2] = '{a: 8'hA5, b: 8'h5A, ci: 1'b1, s: 8'h00, co: 1'b1};
    vecs[3] = '{a: 8'h7F, b: 8'h01, ci: 1'b0, s: 8'h80, co: 1'b0};
    vecs[4] = '{a: 8'h80, b: 8'h80, ci: 1'b0, s: 8'h00, co: 1'b1};
    vecs[5] = '{a: 8'hFF, b: 8'hFF, ci: 1'b1, s: 8'hFF, co: 1'b1};
    vecs[6] = '{a: 8'h0F, b: 8'h01, ci: 1'b0, s: 8'h10, co: 1'b0};
    vecs[7] = '{a: 8'h55, b: 8'h22, ci: 1'b1, s: 8'h78, co: 1'b0};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_a      = '0;
    in_b      = '0;
    in_ci     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset out_s", 32'(out_s), 32'd0);
    check("reset out_co", 32'(out_co), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_job(vecs[i].a, vecs[i].b, vecs[i].ci, lat, bc, s, co);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'd8);
      check($sformatf("vec%0d out_s", i), 32'(s), 32'(vecs[i].s));
      check($sformatf("vec%0d out_co", i), 32'(co), 32'(vecs[i].co));
      if (i == 0) check("vec0 busy cycles", 32'(bc), 32'd9);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d back to idle", i), 32'({in_ready, busy, out_valid}), 32'b100);
    end

    // Backpressure: result must hold while out_ready is low; in_valid pulses are ignored.
    out_ready = 1'b0;
    run_job(8'hC3, 8'h3C, 1'b0, lat, bc, s, co);
    check("bp latency", 32'(lat), 32'd8);
    check("bp out_s", 32'(s), 32'hFF);
    check("bp out_co", 32'(co), 32'd0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom);
      @(posedge clk);
      #1;
      check($sformatf("bp hold %0d", i), 32'({out_valid, in_ready, out_co, out_s}),
            32'({1'b1, 1'b0, 1'b0, 8'hFF}));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp handoff", 32'({in_ready, out_valid, busy}), 32'b100);

    // Reset on the third RUN cycle discards the job.
    @(negedge clk);
    in_a     = 8'hFF;
    in_b     = 8'hFF;
    in_ci    = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst mid-run flags", 32'({in_ready, out_valid, busy}), 32'b100);
    check("rst mid-run out", 32'({out_co, out_s}), 32'd0);
    run_job(8'h12, 8'h34, 1'b0, lat, bc, s, co);
    check("post-rst latency", 32'(lat), 32'd8);
    check("post-rst out_s", 32'(s), 32'h46);
    check("post-rst out_co", 32'(co), 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back with in_valid and out_ready both held high.
    in_valid = 1'b1;
    jobs     = 0;
    first    = 1'b1;
    acc_edge = 0;
    exp_sum  = '0;
    iters    = 0;
    while (jobs < 500 && iters < 500 * 12 + 50) begin
      @(negedge clk);
      iters++;
      if (out_valid) begin
        check("b2b latency", 32'(cyc - acc_edge), 32'd8);
        check("b2b sum", 32'({out_co, out_s}), 32'(exp_sum));
        jobs++;
      end
      if (in_ready) begin
        in_a    = W'($urandom);
        in_b    = W'($urandom);
        in_ci   = 1'($urandom);
        exp_sum = {1'b0, in_a} + {1'b0, in_b} + {{W{1'b0}}, in_ci};
        if (!first) check("b2b spacing", 32'(cyc + 1 - acc_edge), 32'd10);
        acc_edge = cyc + 1;
        first    = 1'b0;
      end
    end
    check("b2b job count", 32'(jobs), 32'd500);
    in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
